// File: rtl/chroma_synth.sv
// chroma_synth: NES-style composite chroma/luma sample generator; optional emphasis via CHROMA_SYNTH_EMPHASIS_EN
module chroma_synth #(
  parameter int ACC_W     = 24,
  parameter int FCW       = 1201096,
  parameter int PHASE_W   = 8,
  parameter int PIX_DIV   = 8,
  parameter int BURST_CYC = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       colour_num,
  input  logic             pix_valid,
  output logic             pix_ready,
  input  logic             line_start,
  input  logic             line_end,
  input  logic             sync,
  input  logic [2:0]       emph,
  input  logic             fcw_load,
  input  logic [ACC_W-1:0] fcw_in,
  output logic [7:0]       video,
  output logic [1:0]       state,
  output logic             underrun
);
  localparam int DIV_W = $clog2(PIX_DIV);
  localparam int CNT_W = $clog2(BURST_CYC + 1);
  localparam logic [31:0] LO = {8'd144, 8'd96, 8'd64, 8'd40};
  localparam logic [31:0] HI = {8'd236, 8'd188, 8'd140, 8'd96};
  localparam logic [7:0] BLANK = 8'd40;
  typedef enum logic [1:0] {IDLE = 2'd0, BURST = 2'd1, ACTIVE = 2'd2} state_t;
  state_t st, st_nxt;
  logic [ACC_W-1:0] acc, acc_nxt, fcw_reg;
  logic [CNT_W-1:0] cnt;
  logic [DIV_W-1:0] div;
  logic [5:0] pix;
  logic [3:0] sec;
  logic wrap;
  logic [7:0] lo_l, hi_l, pix_lvl, act_lvl, video_nxt;
  function automatic logic hue_high(input logic [3:0] h, input logic [3:0] s);
    logic [4:0] d;
    d = {1'b0, s} + 5'd13 - {1'b0, h};
    return (d >= 5'd12 ? d - 5'd12 : d) < 5'd6;
  endfunction
  assign acc_nxt = acc + fcw_reg;
  assign wrap = acc[ACC_W-1] & ~acc_nxt[ACC_W-1];
  assign sec = 4'(({4'b0, acc[ACC_W-1 -: PHASE_W]} * (PHASE_W+4)'(12)) >> PHASE_W);
  assign pix_ready = (st == ACTIVE) && (div == DIV_W'(PIX_DIV - 1));
  assign state = st;
  // Pixel level from luma/hue of the held pixel against the current subcarrier sector
  always_comb begin
    lo_l = LO[{pix[5:4], 3'b000} +: 8];
    hi_l = HI[{pix[5:4], 3'b000} +: 8];
    pix_lvl = pix[3:0] == 4'd0  ? hi_l :
              pix[3:0] <= 4'd12 ? (hue_high(pix[3:0], sec) ? hi_l : lo_l) :
              pix[3:0] == 4'd13 ? lo_l : BLANK;
  end
`ifdef CHROMA_SYNTH_EMPHASIS_EN
  logic emph_hit;
  assign emph_hit = (emph[0] & hue_high(4'd4, sec)) | (emph[1] & hue_high(4'd8, sec)) |
                    (emph[2] & hue_high(4'd12, sec));
  assign act_lvl = emph_hit ? pix_lvl - (pix_lvl >> 2) : pix_lvl;
`else
  logic emph_unused;
  assign emph_unused = ^emph;
  assign act_lvl = pix_lvl;
`endif
  // Next DAC sample: sync overrides, otherwise level chosen by current state
  always_comb begin
    video_nxt = sync          ? 8'd0 :
                st == BURST   ? (hue_high(4'd8, sec) ? 8'd56 : 8'd24) :
                st == ACTIVE  ? act_lvl : BLANK;
  end
  // Line sequencing: line_end dominates, line_start (re)starts burst, burst ends after BURST_CYC wraps
  always_comb begin
    st_nxt = st;
    if (line_end) st_nxt = IDLE;
    else if (line_start) st_nxt = BURST;
    else if (st == BURST && wrap && cnt == CNT_W'(BURST_CYC - 1)) st_nxt = ACTIVE;
    else if (st != IDLE && st != BURST && st != ACTIVE) st_nxt = IDLE;
  end
  // State, phase accumulator, counters, pixel register and output sample
  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
      fcw_reg <= ACC_W'(FCW);
      st <= IDLE;
      cnt <= '0;
      div <= '0;
      pix <= 6'h0F;
      video <= BLANK;
      underrun <= 1'b0;
    end else begin
      acc <= acc_nxt;
      fcw_reg <= fcw_load ? fcw_in : fcw_reg;
      st <= st_nxt;
      cnt <= (line_end || line_start || st != BURST) ? '0 : cnt + CNT_W'(wrap);
      div <= (line_end || line_start || st != ACTIVE || pix_ready) ? '0 : div + 1'b1;
      pix <= st != ACTIVE ? 6'h0F : pix_ready ? (pix_valid ? colour_num : 6'h0F) : pix;
      video <= video_nxt;
      underrun <= underrun | (pix_ready & ~pix_valid);
    end
  end
endmodule
